// File: rtl/Tipos.sv
// Shared lock types and constants.
//   senhaPac_t    : 20-digit BCD word, digit [0] is the most recently typed one
//   KEY_STAR      : clear / abort key code from the keypad decoder
//   KEY_HASH      : confirm key code from the keypad decoder
//   DIGITS_BLANK  : empty buffer (every digit 0xF)
//   DIGITS_ABORT  : abort/exit code handed to consumers (every digit 0xB)
package Tipos;

    localparam int NUM_DIGITS = 20;

    typedef logic [NUM_DIGITS-1:0][3:0] senhaPac_t;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    localparam senhaPac_t DIGITS_BLANK = {NUM_DIGITS{4'hF}};
    localparam senhaPac_t DIGITS_ABORT = {NUM_DIGITS{4'hB}};

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_digits_inactivity_timer.sv
// inactivity_timer: up-counter that flags LIMIT cycles of inactivity.
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   clear   : reload the count to 0 (wins over enable)
//   enable  : count this cycle
//   expired : one-cycle pulse while the count sits at LIMIT-1 and is enabled
module inactivity_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;
    logic         at_limit;

    assign at_limit = (count == W'(LIMIT - 1));

    // A clear on the firing cycle suppresses the pulse, so a key arriving
    // exactly at the limit keeps the entry alive.
    assign expired = enable && !clear && at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_limit ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_digits.sv
// keypad_digits: accumulates keypad digit events into a 20-digit BCD word
// for the lock's setup and unlock stages.
//   clk           : system clock
//   rst           : asynchronous, active-high reset
//   key_valid     : one-cycle key-press pulse
//   key_code      : 0x0-0x9 digit, 0xA star, 0xB hash, 0xC-0xF ignored
//   digitos_value : typed digits (live echo), digit [0] most recent, 0xF unused
//   digitos_valid : one-cycle commit strobe
//   digit_count   : digits held, 0-20
// Build option: define KEYPAD_TIMEOUT_EN to discard an unfinished entry after
// TIMEOUT_CYCLES idle cycles; otherwise TIMEOUT_CYCLES is ignored.
//
// state   | meaning
// --------+---------------------------------------------------------
// EMPTY   | no digits held, outputs blank
// COLLECT | one or more digits held, echoed on digitos_value
// EMIT    | commit cycle, digitos_valid high, buffer clears next cycle
module keypad_digits
    import Tipos::*;
#(
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output logic [4:0] digit_count
);

    typedef enum logic [1:0] {
        EMPTY,
        COLLECT,
        EMIT
    } state_t;

    state_t     state, state_nxt;
    senhaPac_t  value_nxt;
    logic [4:0] count_nxt;
    logic       valid_nxt;

    logic       key_valid_q;
    logic [3:0] key_code_q;
    logic       timeout_fire;

    // Keys are registered before the FSM so no key_* path reaches the
    // outputs. A pulse seen while the commit is on the outputs is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            key_valid_q <= key_valid && (state != EMIT);
            key_code_q  <= key_code;
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    assign timer_enable = (state == COLLECT);
    assign timer_clear  = (key_valid_q && (key_code_q <= KEY_HASH)) ||
                          (state != COLLECT);

    inactivity_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timeout_fire)
    );
`else
    // Parameter stays on the interface so both builds share one instantiation.
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            digitos_value <= DIGITS_BLANK;
            digitos_valid <= 1'b0;
            digit_count   <= 5'd0;
        end else begin
            state         <= state_nxt;
            digitos_value <= value_nxt;
            digitos_valid <= valid_nxt;
            digit_count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        value_nxt = digitos_value;
        count_nxt = digit_count;
        valid_nxt = 1'b0;

        case (state)
            EMPTY, COLLECT: begin
                if (key_valid_q && is_digit(key_code_q)) begin
                    // Oldest digit falls off the top once 20 are held.
                    value_nxt = {digitos_value[NUM_DIGITS-2:0], key_code_q};
                    count_nxt = (digit_count == 5'(NUM_DIGITS)) ?
                                digit_count : digit_count + 5'd1;
                    state_nxt = COLLECT;
                end else if (key_valid_q && key_code_q == KEY_HASH) begin
                    // Empty confirm commits the blank word ("skip").
                    if (state == EMPTY) begin
                        value_nxt = DIGITS_BLANK;
                        count_nxt = 5'd0;
                    end
                    valid_nxt = 1'b1;
                    state_nxt = EMIT;
                end else if (key_valid_q && key_code_q == KEY_STAR) begin
                    if (state == EMPTY) begin
                        value_nxt = DIGITS_ABORT;
                        count_nxt = 5'd0;
                        valid_nxt = 1'b1;
                        state_nxt = EMIT;
                    end else begin
                        value_nxt = DIGITS_BLANK;
                        count_nxt = 5'd0;
                        state_nxt = EMPTY;
                    end
                end else if (timeout_fire) begin
                    value_nxt = DIGITS_BLANK;
                    count_nxt = 5'd0;
                    state_nxt = EMPTY;
                end
            end
            EMIT: begin
                value_nxt = DIGITS_BLANK;
                count_nxt = 5'd0;
                state_nxt = EMPTY;
            end
            default: begin
                value_nxt = DIGITS_BLANK;
                count_nxt = 5'd0;
                state_nxt = EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_digits.sv
// Testbench for keypad_digits: directed vector table, hand-written corner
// sequences (overflow, key during commit, reset mid-entry, inactivity timeout
// when KEYPAD_TIMEOUT_EN is defined) and a random key stream checked against
// a queue-based model of the digit buffer.
module tb_keypad_digits;
    import Tipos::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    logic [4:0] digit_count;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    always #5 clk = ~clk;

    keypad_digits #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .digit_count   (digit_count)
    );

    always @(negedge clk) if (digitos_valid === 1'b1) strobes++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] code;
        bit         exp_valid;
        int         exp_count;
        senhaPac_t  exp_value;
    } vec_t;

    vec_t vecs[16];

    // Model: queue of typed digits, element 0 is the most recent.
    int mq[$];

    function automatic senhaPac_t model_pack();
        senhaPac_t v = DIGITS_BLANK;
        for (int i = 0; i < mq.size(); i++) v[i] = 4'(mq[i]);
        return v;
    endfunction

    task automatic model_key(input logic [3:0] k, output senhaPac_t ev,
                             output int ec, output bit evld);
        evld = 1'b0;
        if (k <= 4'd9) begin
            mq.push_front(int'(k));
            if (mq.size() > 20) void'(mq.pop_back());
            ev = model_pack();
            ec = mq.size();
        end else if (k == 4'hA) begin
            if (mq.size() == 0) begin
                ev = DIGITS_ABORT; ec = 0; evld = 1'b1;
            end else begin
                mq.delete(); ev = DIGITS_BLANK; ec = 0;
            end
        end else if (k == 4'hB) begin
            ev = model_pack(); ec = mq.size(); evld = 1'b1;
            mq.delete();
        end else begin
            ev = model_pack(); ec = mq.size();
        end
    endtask

    task automatic check(input string name, input senhaPac_t ev, input int ec, input bit evld);
        checks++;
        if (digitos_value !== ev || digit_count !== 5'(ec) || digitos_valid !== evld) begin
            failures++;
            $display("FAIL %s: got value=%h count=%0d valid=%b, want value=%h count=%0d valid=%b",
                     name, digitos_value, digit_count, digitos_valid, ev, ec, evld);
        end
    endtask

    task automatic checkeq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Key sampled on the posedge between the two negedges.
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
    endtask

    senhaPac_t ev;
    int        ec;
    bit        evld;
    int        s0;

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clk);
        check("reset", DIGITS_BLANK, 0, 0);
        rst = 1'b0;

        vecs[0]  = '{4'h1, 1'b0, 1, {{19{4'hF}}, 4'h1}};
        vecs[1]  = '{4'h2, 1'b0, 2, {{18{4'hF}}, 4'h1, 4'h2}};
        vecs[2]  = '{4'h3, 1'b0, 3, {{17{4'hF}}, 4'h1, 4'h2, 4'h3}};
        vecs[3]  = '{4'h4, 1'b0, 4, {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4}};
        vecs[4]  = '{4'hB, 1'b1, 4, {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4}};
        vecs[5]  = '{4'hB, 1'b1, 0, {20{4'hF}}};
        vecs[6]  = '{4'hA, 1'b1, 0, {20{4'hB}}};
        vecs[7]  = '{4'h5, 1'b0, 1, {{19{4'hF}}, 4'h5}};
        vecs[8]  = '{4'h6, 1'b0, 2, {{18{4'hF}}, 4'h5, 4'h6}};
        vecs[9]  = '{4'hA, 1'b0, 0, {20{4'hF}}};
        vecs[10] = '{4'h7, 1'b0, 1, {{19{4'hF}}, 4'h7}};
        vecs[11] = '{4'hB, 1'b1, 1, {{19{4'hF}}, 4'h7}};
        vecs[12] = '{4'hD, 1'b0, 0, {20{4'hF}}};
        vecs[13] = '{4'h8, 1'b0, 1, {{19{4'hF}}, 4'h8}};
        vecs[14] = '{4'hE, 1'b0, 1, {{19{4'hF}}, 4'h8}};
        vecs[15] = '{4'hA, 1'b0, 0, {20{4'hF}}};

        for (int i = 0; i < 16; i++) begin
            press(vecs[i].code);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp_value, vecs[i].exp_count, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                @(negedge clk);
                check($sformatf("vec%0d_clear", i), DIGITS_BLANK, 0, 0);
            end
        end

        // Overflow: 0..9,0..9,3 then confirm.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            logic [3:0] k;
            k = (i < 20) ? 4'(i % 10) : 4'h3;
            model_key(k, ev, ec, evld);
            press(k);
            @(negedge clk);
            check($sformatf("ovf_digit%0d", i), ev, ec, evld);
        end
        model_key(KEY_HASH, ev, ec, evld);
        press(KEY_HASH);
        @(negedge clk);
        check("ovf_commit", ev, ec, evld);
        checkeq("ovf_count", int'(digit_count), 20);
        checkeq("ovf_d0", int'(digitos_value[0]), 3);
        checkeq("ovf_d19", int'(digitos_value[19]), 1);
        @(negedge clk);
        check("ovf_clear", DIGITS_BLANK, 0, 0);

        // Key pulse during the commit cycle is dropped.
        press(4'h5);
        @(negedge clk);
        press(KEY_HASH);
        @(negedge clk);
        check("emit_commit", {{19{4'hF}}, 4'h5}, 1, 1);
        key_valid = 1'b1;
        key_code  = 4'h7;
        @(negedge clk);
        key_valid = 1'b0;
        check("emit_clear", DIGITS_BLANK, 0, 0);
        @(negedge clk);
        check("emit_key_dropped", DIGITS_BLANK, 0, 0);
        @(negedge clk);
        check("emit_key_dropped2", DIGITS_BLANK, 0, 0);

        // Reset mid-entry.
        s0 = strobes;
        press(4'h8);
        @(negedge clk);
        check("rst_pre", {{19{4'hF}}, 4'h8}, 1, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_entry", DIGITS_BLANK, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", DIGITS_BLANK, 0, 0);
        checkeq("rst_mid_nostrobe", strobes, s0);

        // Reset during the commit cycle.
        press(4'h6);
        @(negedge clk);
        press(KEY_HASH);
        @(negedge clk);
        check("rst_emit_pre", {{19{4'hF}}, 4'h6}, 1, 1);
        rst = 1'b1;
        #1;
        check("rst_in_emit", DIGITS_BLANK, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_emit_after", DIGITS_BLANK, 0, 0);

`ifdef KEYPAD_TIMEOUT_EN
        s0 = strobes;
        press(4'h9);
        @(negedge clk);
        check("to_hold0", {{19{4'hF}}, 4'h9}, 1, 0);
        repeat (15) @(negedge clk);
        check("to_hold15", {{19{4'hF}}, 4'h9}, 1, 0);
        @(negedge clk);
        check("to_cleared", DIGITS_BLANK, 0, 0);
        checkeq("to_nostrobe", strobes, s0);

        press(4'h9);
        @(negedge clk);
        repeat (13) @(negedge clk);
        press(4'h4);
        @(negedge clk);
        check("to_key_wins", {{18{4'hF}}, 4'h9, 4'h4}, 2, 0);
        repeat (15) @(negedge clk);
        check("to_reload_hold", {{18{4'hF}}, 4'h9, 4'h4}, 2, 0);
        @(negedge clk);
        check("to_reload_cleared", DIGITS_BLANK, 0, 0);
        checkeq("to_nostrobe2", strobes, s0);
`else
        press(4'h9);
        @(negedge clk);
        repeat (40) @(negedge clk);
        check("no_timeout_hold", {{19{4'hF}}, 4'h9}, 1, 0);
        press(KEY_STAR);
        @(negedge clk);
        check("no_timeout_star", DIGITS_BLANK, 0, 0);
`endif

        // Random key stream against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [3:0] k;
            k = 4'($urandom_range(15, 0));
            model_key(k, ev, ec, evld);
            press(k);
            @(negedge clk);
            check($sformatf("rand%0d_code%0h", n, k), ev, ec, evld);
            if (evld) begin
                @(negedge clk);
                check($sformatf("rand%0d_clear", n), DIGITS_BLANK, 0, 0);
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_digits.md
# keypad_digits

Keypad digit accumulator for the electronic lock. It turns single-key events from the debounced keypad decoder into a 20-digit BCD word (`senhaPac_t`) with a one-cycle `digitos_valid` strobe. It sits directly upstream of the setup and unlock stages, which consume `digitos_value` and `digitos_valid`. Between commits, `digitos_value` also serves as a live echo of the keys typed so far, for display.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 250_000_000: inactivity limit in clk cycles; an unfinished entry is discarded when it expires (5 s at 50 MHz).

Ports (reset `rst` is asynchronous, active-high; clock is `clk`):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: one-cycle pulse, a key was pressed.
- `key_code` in 4: `0x0`–`0x9` digit, `0xA` `KEY_STAR`, `0xB` `KEY_HASH`; `0xC`–`0xF` are ignored.
- `digitos_value` out `senhaPac_t` (80): `digits[0]` is the most recent digit; unused digits are `0xF`.
- `digitos_valid` out 1: one-cycle commit strobe.
- `digit_count` out 5: number of digits held, 0–20.

## Operation
- Reset values:
  - `digitos_value` = all `0xF`
  - `digitos_valid` = 0
  - `digit_count` = 0
  - state = `EMPTY`
- States: `EMPTY`, `COLLECT`, `EMIT`.
- Digit key in `EMPTY` or `COLLECT`:
  - shift `digits[i+1] <= digits[i]`, then `digits[0] <= key`;
  - `digit_count` increments, saturating at 20;
  - go to `COLLECT`.
- Overflow: a digit entered with 20 digits held drops `digits[19]`; `digit_count` stays 20.
- `KEY_HASH` (confirm) in `COLLECT`: go to `EMIT`; `digitos_value` keeps the typed digits.
- `KEY_HASH` in `EMPTY`: go to `EMIT` with `digitos_value` = all `0xF`. This means "keep current value / skip" to consumers.
- `KEY_STAR` in `COLLECT`: clear to all `0xF`, `digit_count` = 0, go to `EMPTY`. No strobe.
- `KEY_STAR` in `EMPTY`: load all `0xB`, go to `EMIT`. This is the abort/exit code for consumers.
- `EMIT` lasts exactly one cycle:
  - `digitos_valid` = 1 during it;
  - next cycle: `digitos_value` = all `0xF`, `digit_count` = 0, state `EMPTY`.
- Codes `0xC`–`0xF` have no effect in any state.

## Timing
- Every output is a register output; there is no combinational path from `key_*` to the outputs.
- `key_valid` at edge N:
  - the updated `digitos_value` and `digit_count` are visible after edge N+1;
  - the commit strobe is high during cycle N+1 only;
  - the buffer is cleared after edge N+2.
- `key_valid` during the `EMIT` cycle is dropped, not queued. The upstream decoder guarantees at least 2 cycles between key pulses.
- Timeout: a counter of width `$clog2(TIMEOUT_CYCLES+1)`, active only in `COLLECT`.
  - It reloads to 0 on every accepted key.
  - On reaching `TIMEOUT_CYCLES - 1` it clears the buffer and returns to `EMPTY`. No strobe is issued.
  - If a key arrives on the same cycle the timeout would fire, the key wins and the counter reloads.
- `rst` asserted mid-entry or during `EMIT` returns all outputs to their reset values immediately; no strobe is emitted.

## Configuration
- Macro: `KEYPAD_TIMEOUT_EN`.
  - Defined: inactivity timeout behaves as specified above.
  - Undefined: no timeout counter is built; an entry stays in `COLLECT` until `KEY_HASH`, `KEY_STAR` or `rst`; `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `Tipos.sv` holds:
  - `senhaPac_t`;
  - new constants `KEY_STAR` = `4'hA`, `KEY_HASH` = `4'hB`;
  - `DIGITS_BLANK` = `{20{4'hF}}`, `DIGITS_ABORT` = `{20{4'hB}}`;
  - the state enum stays local to the module.
- One sub-module, `inactivity_timer`: counter with `clear`/`enable` inputs and an `expired` pulse output. It is instantiated only under `KEYPAD_TIMEOUT_EN`.

## Test plan
- Reset, then keys 1,2,3,4, then `#` → strobe for one cycle with `digits[3:0]` = 1,2,3,4 (MSD→LSD) and `digits[19:4]` = `0xF`; next cycle all `0xF`, `digit_count` = 0.
- `#` with empty buffer → strobe with all `0xF`; `*` with empty buffer → strobe with all `0xB`.
- Keys 5,6, then `*` → no strobe, buffer all `0xF`, count 0; then 7, `#` → strobe, `digits[0]` = 7.
- 21 digits 0..9,0..9,3, then `#` → count 20, `digits[0]` = 3, oldest `0` dropped, `digits[19]` = 1.
- `KEYPAD_TIMEOUT_EN` with `TIMEOUT_CYCLES` = 16: key 9, idle 16 cycles → buffer cleared, no strobe. Repeat with a key on cycle 15 → no clear.
- Key during `EMIT` cycle dropped; `rst` pulse after key 8 → all `0xF`, count 0, no strobe; code `0xD` → no change.
